// File: rtl/shield_mask_writer_if.sv
// Command and mask-RAM write bundle for shield_mask_writer.
// The slave modport is the writer's view; the master modport is the command source and RAM side.
interface shield_mask_writer_if #(
  parameter int SECT_W = 4,
  parameter int CELL_W = 7
);
  logic                     clear_req;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [SECT_W-1:0]        cmd_sector;
  logic [CELL_W-1:0]        cmd_start;
  logic [CELL_W-1:0]        cmd_end;
  logic                     cmd_value;
  logic                     wren;
  logic [SECT_W+CELL_W-1:0] wraddr;
  logic                     wrdata;
  logic                     busy;
  logic                     done;

  modport slave (
    input  clear_req, cmd_valid, cmd_sector, cmd_start, cmd_end, cmd_value,
    output cmd_ready, wren, wraddr, wrdata, busy, done
  );

  modport master (
    output clear_req, cmd_valid, cmd_sector, cmd_start, cmd_end, cmd_value,
    input  cmd_ready, wren, wraddr, wrdata, busy, done
  );
endinterface

// File: rtl/shield_mask_writer.sv
// Shield mask RAM writer: turns clear requests and sector/range-cell fill commands
// into one-write-per-clock streams on the mask RAM write port (1 = pass, 0 = blank).
module shield_mask_writer #(
  parameter int   SECT_W      = 4,
  parameter int   CELL_W      = 7,
  parameter logic CLEAR_VALUE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  shield_mask_writer_if.slave bus
);

  localparam int ADDR_W = SECT_W + CELL_W;

  typedef enum logic [1:0] {IDLE, CLEAR, FILL, DONE} state_t;

  state_t              state_q, state_d;
  logic                clear_pend_q, clear_pend_d;
  logic [CELL_W-1:0]   end_q, end_d;
  logic                value_q, value_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   wraddr_q, wraddr_d;
  logic                wrdata_q, wrdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                start_clear;
  logic [CELL_W-1:0]   cell_cur;
  logic [CELL_W-1:0]   cell_nxt;

  // In FILL the low address bits are the cell being written; the upper bits hold the latched sector.
  assign cell_cur = wraddr_q[CELL_W-1:0];
  assign cell_nxt = cell_cur + 1'b1;

  assign bus.cmd_ready = (state_q == IDLE) && !clear_pend_q && !bus.clear_req && !reset;

  always_comb begin
    state_d      = state_q;
    clear_pend_d = clear_pend_q;
    end_d        = end_q;
    value_d      = value_q;
    wren_d       = 1'b0;
    wraddr_d     = wraddr_q;
    wrdata_d     = wrdata_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    start_clear  = 1'b0;

    if (bus.clear_req && (state_q != IDLE)) clear_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.clear_req || clear_pend_q) begin
          start_clear = 1'b1;
        end else if (bus.cmd_valid) begin
          state_d  = FILL;
          wren_d   = 1'b1;
          wraddr_d = {bus.cmd_sector, bus.cmd_start};
          wrdata_d = bus.cmd_value;
          end_d    = bus.cmd_end;
          value_d  = bus.cmd_value;
          busy_d   = 1'b1;
        end
      end
      CLEAR: begin
        if (wraddr_q == '1) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          wren_d   = 1'b1;
          wraddr_d = wraddr_q + 1'b1;
          wrdata_d = CLEAR_VALUE;
          busy_d   = 1'b1;
        end
      end
      FILL: begin
        if (cell_cur == end_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          wren_d   = 1'b1;
          wraddr_d = {wraddr_q[ADDR_W-1:CELL_W], cell_nxt};
          wrdata_d = value_q;
          busy_d   = 1'b1;
        end
      end
      DONE: begin
        if (bus.clear_req || clear_pend_q) start_clear = 1'b1;
        else                               state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Entering CLEAR consumes every pending request: repeated pulses merge into this one pass.
    if (start_clear) begin
      state_d      = CLEAR;
      clear_pend_d = 1'b0;
      wren_d       = 1'b1;
      wraddr_d     = '0;
      wrdata_d     = CLEAR_VALUE;
      busy_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      clear_pend_q <= 1'b0;
      end_q        <= '0;
      value_q      <= 1'b0;
      wren_q       <= 1'b0;
      wraddr_q     <= '0;
      wrdata_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_pend_q <= clear_pend_d;
      end_q        <= end_d;
      value_q      <= value_d;
      wren_q       <= wren_d;
      wraddr_q     <= wraddr_d;
      wrdata_q     <= wrdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.wren   = wren_q;
  assign bus.wraddr = wraddr_q;
  assign bus.wrdata = wrdata_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_shield_mask_writer.sv
// Directed bench for shield_mask_writer: a negedge monitor logs every write, done,
// busy cycle and handshake; directed scenarios compare the log with hand-derived values.
module tb_shield_mask_writer;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  shield_mask_writer_if #(.SECT_W(4), .CELL_W(7)) mif ();

  shield_mask_writer #(.SECT_W(4), .CELL_W(7), .CLEAR_VALUE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [10:0] wr_addr[$];
  logic        wr_data[$];
  int          wr_cyc[$];
  int          done_cyc[$];
  int          acc_cyc[$];
  int          busy_cnt = 0;

  always @(negedge clk) begin
    if (mif.wren) begin
      wr_addr.push_back(mif.wraddr);
      wr_data.push_back(mif.wrdata);
      wr_cyc.push_back(cyc);
    end
    if (mif.done) done_cyc.push_back(cyc);
    if (mif.busy) busy_cnt = busy_cnt + 1;
    if (mif.cmd_valid && mif.cmd_ready) acc_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int b;
    b = 0;
    while (done_cyc.size() <= d0 && b < budget) begin
      tick();
      b++;
    end
    check("done_seen", done_cyc.size() > d0, 1);
  endtask

  task automatic wait_accept(input int a0, input int budget);
    int b;
    b = 0;
    while (acc_cyc.size() <= a0 && b < budget) begin
      tick();
      b++;
    end
    check("accept_seen", acc_cyc.size() > a0, 1);
    // Scramble the command after acceptance: it must have been latched already.
    mif.cmd_valid  = 1'b0;
    mif.cmd_sector = 4'hA;
    mif.cmd_start  = 7'h55;
    mif.cmd_end    = 7'h2A;
    mif.cmd_value  = ~mif.cmd_value;
  endtask

  task automatic send_cmd(input logic [3:0] s, input logic [6:0] a, input logic [6:0] e, input logic v);
    mif.cmd_sector = s;
    mif.cmd_start  = a;
    mif.cmd_end    = e;
    mif.cmd_value  = v;
    mif.cmd_valid  = 1'b1;
  endtask

  task automatic check_seq(input string tag, input int bw, input int ai, input int di,
                           input logic [10:0] exp[$], input logic exp_d);
    int n;
    int bad;
    n = wr_addr.size() - bw;
    check({tag, "_cnt"}, n, exp.size());
    if (n == exp.size() && n > 0) begin
      bad = 0;
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s_addr%0d", tag, i), {21'd0, wr_addr[bw+i]}, {21'd0, exp[i]});
        if (wr_data[bw+i] !== exp_d || wr_cyc[bw+i] != wr_cyc[bw] + i) bad++;
      end
      check({tag, "_data_contig"}, bad, 0);
      if (acc_cyc.size() > ai) check({tag, "_first_lat"}, wr_cyc[bw], acc_cyc[ai] + 1);
      if (done_cyc.size() > di) check({tag, "_done_lat"}, done_cyc[di], wr_cyc[bw+n-1] + 1);
    end
  endtask

  function automatic int clear_bad(input int bw);
    int bad;
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      if (bw + i >= wr_addr.size()) bad++;
      else if (wr_addr[bw+i] !== 11'(i) || wr_data[bw+i] !== 1'b1 ||
               wr_cyc[bw+i] != wr_cyc[bw] + i) bad++;
    end
    return bad;
  endfunction

  initial begin
    int bw, bd, bb, ba, creq, n;
    logic [10:0] exp[$];

    reset          = 1'b1;
    mif.clear_req  = 1'b0;
    mif.cmd_valid  = 1'b0;
    mif.cmd_sector = '0;
    mif.cmd_start  = '0;
    mif.cmd_end    = '0;
    mif.cmd_value  = 1'b0;
    repeat (3) tick();

    check("rst_wren",   mif.wren, 0);
    check("rst_done",   mif.done, 0);
    check("rst_busy",   mif.busy, 0);
    check("rst_wraddr", mif.wraddr, 0);
    check("rst_wrdata", mif.wrdata, 0);
    check("rst_ready",  mif.cmd_ready, 0);
    reset = 1'b0;
    tick();
    check("idle_ready", mif.cmd_ready, 1);

    // Full clear
    bw = wr_addr.size(); bd = done_cyc.size(); bb = busy_cnt;
    mif.clear_req = 1'b1;
    creq = cyc;
    tick();
    mif.clear_req = 1'b0;
    wait_done(bd, 3000);
    repeat (3) tick();
    check("clr_cnt", wr_addr.size() - bw, 2048);
    check("clr_seq_bad", clear_bad(bw), 0);
    check("clr_first_lat", wr_cyc[bw], creq + 1);
    if (done_cyc.size() > bd) check("clr_done_lat", done_cyc[bd], wr_cyc[bw] + 2047 + 1);
    check("clr_done_pulses", done_cyc.size() - bd, 1);
    check("clr_busy_cycles", busy_cnt - bb, 2048);

    // Fill sector 3, cells 10..13, value 0
    bw = wr_addr.size(); bd = done_cyc.size(); ba = acc_cyc.size();
    send_cmd(4'd3, 7'd10, 7'd13, 1'b0);
    wait_accept(ba, 50);
    wait_done(bd, 200);
    repeat (3) tick();
    exp = '{11'h18A, 11'h18B, 11'h18C, 11'h18D};
    check_seq("fill3", bw, ba, bd, exp, 1'b0);
    check("hold_wraddr", mif.wraddr, 11'h18D);
    check("hold_wren", mif.wren, 0);

    // Wrap fill sector 15, cells 126..1
    bw = wr_addr.size(); bd = done_cyc.size(); ba = acc_cyc.size();
    send_cmd(4'd15, 7'd126, 7'd1, 1'b0);
    wait_accept(ba, 50);
    wait_done(bd, 200);
    repeat (2) tick();
    exp = '{11'h7FE, 11'h7FF, 11'h780, 11'h781};
    check_seq("wrap", bw, ba, bd, exp, 1'b0);

    // Single cell
    bw = wr_addr.size(); bd = done_cyc.size(); ba = acc_cyc.size();
    send_cmd(4'd0, 7'd50, 7'd50, 1'b0);
    wait_accept(ba, 50);
    wait_done(bd, 200);
    repeat (2) tick();
    exp = '{11'h032};
    check_seq("single", bw, ba, bd, exp, 1'b0);

    // Full sector: 51..127 then 0..50
    bw = wr_addr.size(); bd = done_cyc.size(); ba = acc_cyc.size();
    send_cmd(4'd0, 7'd51, 7'd50, 1'b1);
    wait_accept(ba, 50);
    wait_done(bd, 400);
    repeat (2) tick();
    exp.delete();
    for (int i = 51; i < 128; i++) exp.push_back(11'(i));
    for (int i = 0; i <= 50; i++) exp.push_back(11'(i));
    check_seq("fullsec", bw, ba, bd, exp, 1'b1);

    // Simultaneous clear_req and cmd_valid in IDLE: clear first, command held
    bw = wr_addr.size(); bd = done_cyc.size(); ba = acc_cyc.size();
    send_cmd(4'd5, 7'd20, 7'd21, 1'b0);
    mif.clear_req = 1'b1;
    #1;
    check("sim_ready_low", mif.cmd_ready, 0);
    tick();
    mif.clear_req = 1'b0;
    wait_accept(ba, 3000);
    wait_done(bd + 1, 200);
    repeat (2) tick();
    check("sim_clr_bad", clear_bad(bw), 0);
    check("sim_accepts", acc_cyc.size() - ba, 1);
    if (acc_cyc.size() > ba && done_cyc.size() > bd)
      check("sim_acc_after_done", acc_cyc[ba], done_cyc[bd] + 1);
    exp = '{11'h294, 11'h295};
    check_seq("sim_fill", bw + 2048, ba, bd + 1, exp, 1'b0);

    // clear_req during a fill runs one clear straight after the fill's done
    bw = wr_addr.size(); bd = done_cyc.size(); ba = acc_cyc.size(); bb = busy_cnt;
    send_cmd(4'd3, 7'd0, 7'd9, 1'b1);
    wait_accept(ba, 50);
    tick();
    mif.clear_req = 1'b1;
    tick();
    mif.clear_req = 1'b0;
    tick();
    mif.clear_req = 1'b1;
    tick();
    mif.clear_req = 1'b0;
    wait_done(bd, 200);
    wait_done(bd + 1, 3000);
    repeat (20) tick();
    check("fc_writes", wr_addr.size() - bw, 10 + 2048);
    check("fc_clr_bad", clear_bad(bw + 10), 0);
    if (done_cyc.size() > bd && wr_cyc.size() > bw + 10)
      check("fc_clr_start", wr_cyc[bw+10], done_cyc[bd] + 1);
    check("fc_dones", done_cyc.size() - bd, 2);
    check("fc_busy_cycles", busy_cnt - bb, 10 + 2048);

    // Reset at write 100 of a clear, with a second clear pending
    bw = wr_addr.size(); bd = done_cyc.size();
    mif.clear_req = 1'b1;
    tick();
    mif.clear_req = 1'b0;
    n = 0;
    while (wr_addr.size() - bw < 50 && n < 200) begin tick(); n++; end
    mif.clear_req = 1'b1;
    tick();
    mif.clear_req = 1'b0;
    n = 0;
    while (wr_addr.size() - bw < 100 && n < 200) begin tick(); n++; end
    check("rst_reached_100", wr_addr.size() - bw >= 100, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_wren", mif.wren, 0);
    check("rst_async_busy", mif.busy, 0);
    n = wr_addr.size();
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rel_ready", mif.cmd_ready, 1);
    repeat (30) tick();
    check("rel_no_writes", wr_addr.size() - n, 0);
    check("rel_no_done", done_cyc.size() - bd, 0);
    check("rel_idle_busy", mif.busy, 0);
    check("rel_idle_ready", mif.cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
